multi_timer: RTL and testbench
==============================

# multi_timer

Parametrised multi-channel timer/counter peripheral for the register-strobe peripheral bus. It provides CHANNELS independent up/down counters of WIDTH bits, each with a reload value, a compare value, wrap or auto-reload mode, and one-shot mode. A shared write-1-to-clear status register holds terminal-count and compare-match pending flags, which combine into a single registered interrupt line. An optional global prescaler divides the count tick.

## Interface
- CHANNELS, 4: number of timer channels, 1..16.
- WIDTH, 32: counter, reload and compare width, 1..32.
- PRESCALE_WIDTH, 8: prescaler value width, 1..32.
- REGS, 4*CHANNELS+2: register count (derived; do not override).
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  32  write data from bus master.
- write_en  input  REGS  one-hot per-register write strobe.
- data_out  output  REGS x 32  per-register read data, driven continuously.
- irq_out  output  1  registered interrupt request.

## Operation
- Register map, channel n at base 4n:
  - +0 COUNT[WIDTH-1:0]
  - +1 RELOAD[WIDTH-1:0]
  - +2 COMPARE[WIDTH-1:0]
  - +3 CONFIG: bit0 EN, bit1 DIR (1 = up), bit2 IRE, bit3 MODE (1 = auto-reload), bit4 ONESHOT.
- STATUS is at 4*CHANNELS:
  - bits [CHANNELS-1:0]: terminal pending TP[n].
  - bits [16+CHANNELS-1:16]: compare pending CP[n].
  - W1C: writing 1 clears the bit; writing 0 has no effect.
- PRESCALE is at 4*CHANNELS+1.
- Unused read bits are 0. Write data bits above a field's width are ignored.
- Reset values: every register, pending flag, prescale counter and irq_out is 0, so all data_out words read 0.
- Tick: channel n advances when EN=1 and the global tick is high.
  - Up: COUNT+1.
  - Down: COUNT-1.
- Terminal condition: ticking with COUNT = all-ones (up) or COUNT = 0 (down). On that tick, instead of the normal step:
  - MODE=1: COUNT <= RELOAD.
  - MODE=0: COUNT wraps to 0 (up) or all-ones (down).
  - TP[n] is set.
  - If ONESHOT=1, EN is cleared.
- Compare: ticking with COUNT == COMPARE sets CP[n]. Compare and terminal can both fire on the same tick.
- Priority within a cycle:
  - A COUNT write beats a tick; the written value is loaded and no events fire.
  - A CONFIG write takes effect next cycle; the current tick uses the old CONFIG.
  - A hardware set of TP/CP beats a simultaneous W1C clear of the same bit.
- irq_out is registered: irq_out <= OR over n of ((TP[n] | CP[n]) & IRE[n]).
- Clearing IRE masks the interrupt but leaves pending flags intact.

## Timing
- Write visibility: a write strobed in cycle k is visible on data_out in cycle k+1.
- Event latency: a terminal or compare tick at edge E sets the pending bit at E; irq_out rises at E+1.
- Clear latency: a W1C clear at edge E drops irq_out at E+1, provided no other unmasked pending bit remains.
- Tick rate:
  - Prescaler enabled: the tick is high one cycle in every PRESCALE+1.
  - PRESCALE=0 means every cycle.
  - The first tick after reset or after a PRESCALE write occurs PRESCALE+1 cycles later.
- Synchronous reset mid-count returns all state to reset values at the next edge; writes in that cycle are lost.
- WIDTH < 32: all arithmetic is modulo 2^WIDTH.

## Configuration
- MULTI_TIMER_PRESCALE_EN defined:
  - A PRESCALE_WIDTH-bit PRESCALE register and a prescale counter are built.
  - The counter resets to 0 on any PRESCALE write.
- Not defined:
  - The tick is constantly 1.
  - PRESCALE reads 0 and writes to it are ignored.
  - The register map is unchanged.

## Test plan
- Reset: after reset, all data_out words = 0 and irq_out = 0. Write CONFIG0=0x3 (EN, up) and COUNT0=0xFFFFFFFE in the same cycle. COUNT0 reads 0xFFFFFFFE, then 0xFFFFFFFF, then 0x0. TP0 sets on the wrap tick; irq_out stays 0 (IRE=0).
- Auto-reload, down, one-shot: RELOAD1=5, COUNT1=1, CONFIG1=0x1D (EN, down, IRE, MODE, ONESHOT). Sequence: COUNT1 = 1, 0, then 5. EN clears on the reload tick. irq_out = 1 one cycle after TP1 sets; COUNT1 then holds at 5.
- Compare and W1C:
  - COMPARE2=10, COUNT2=8, up, IRE=1. CP2 (STATUS bit 18) sets when COUNT2 advances from 10.
  - Writing STATUS=0x40000 clears CP2, and irq_out falls one cycle later.
  - A clear issued in the same cycle as a fresh compare set leaves CP2 = 1.
- Write-vs-tick priority: while channel 0 ticks, write COUNT0=100. The next read is 100, not 101, and no event fires even if the old COUNT matched.
- Prescaler (macro defined): PRESCALE=3 with channel 0 counting up from 0 gives COUNT0 increments every 4 cycles. A PRESCALE write mid-period restarts the 4-cycle spacing. Without the macro, PRESCALE reads 0 and COUNT0 increments every cycle.

Source files
------------

// File: rtl/multi_timer.sv
// multi_timer: CHANNELS up/down timers with shared W1C status and a registered irq.
// Build option MULTI_TIMER_PRESCALE_EN adds a global PRESCALE register and tick divider.
module multi_timer_chan #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      data_in,
  input  logic             we_count,
  input  logic             we_reload,
  input  logic             we_compare,
  input  logic             we_config,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] reload,
  output logic [WIDTH-1:0] compare,
  output logic [4:0]       cfg,
  output logic             tp_set,
  output logic             cp_set
);
  logic [WIDTH-1:0] count_q, count_d, reload_q, reload_d, compare_q, compare_d;
  logic [4:0]       cfg_q, cfg_d;
  logic             step, term, up;

  always_comb begin
    count_d   = count_q;
    reload_d  = reload_q;
    compare_d = compare_q;
    cfg_d     = cfg_q;
    tp_set    = 1'b0;
    cp_set    = 1'b0;
    up        = cfg_q[1];
    // A COUNT write suppresses the tick entirely, including its events.
    step      = cfg_q[0] & tick & ~we_count;
    term      = up ? (&count_q) : (count_q == '0);
    if (step) begin
      cp_set = (count_q == compare_q);
      if (term) begin
        tp_set  = 1'b1;
        count_d = cfg_q[3] ? reload_q : (up ? '0 : '1);
        if (cfg_q[4]) cfg_d[0] = 1'b0;
      end else begin
        count_d = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end
    end
    if (we_count)   count_d   = data_in[WIDTH-1:0];
    if (we_reload)  reload_d  = data_in[WIDTH-1:0];
    if (we_compare) compare_d = data_in[WIDTH-1:0];
    if (we_config)  cfg_d     = data_in[4:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      reload_q  <= '0;
      compare_q <= '0;
      cfg_q     <= '0;
    end else begin
      count_q   <= count_d;
      reload_q  <= reload_d;
      compare_q <= compare_d;
      cfg_q     <= cfg_d;
    end
  end

  assign count   = count_q;
  assign reload  = reload_q;
  assign compare = compare_q;
  assign cfg     = cfg_q;
endmodule

module multi_timer #(
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 32,
  parameter int PRESCALE_WIDTH = 8,
  parameter int REGS           = 4*CHANNELS+2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          data_in,
  input  logic [REGS-1:0]      write_en,
  output logic [REGS-1:0][31:0] data_out,
  output logic                 irq_out
);
  localparam int STATUS_IDX = 4*CHANNELS;
  localparam int PRESC_IDX  = 4*CHANNELS+1;

  logic [CHANNELS-1:0][WIDTH-1:0] ch_count, ch_reload, ch_compare;
  logic [CHANNELS-1:0][4:0]       ch_cfg;
  logic [CHANNELS-1:0]            tp_set, cp_set, ire;
  logic [CHANNELS-1:0]            tp_q, tp_d, cp_q, cp_d;
  logic                           irq_q, irq_d, tick;
  logic [31:0]                    status_w, presc_w;

`ifdef MULTI_TIMER_PRESCALE_EN
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d, pcnt_q, pcnt_d;

  always_comb begin
    tick    = (pcnt_q == presc_q);
    presc_d = presc_q;
    pcnt_d  = tick ? '0 : pcnt_q + PRESCALE_WIDTH'(1);
    // A PRESCALE write restarts the period from zero.
    if (write_en[PRESC_IDX]) begin
      presc_d = data_in[PRESCALE_WIDTH-1:0];
      pcnt_d  = '0;
    end
    presc_w = 32'(presc_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end
`else
  logic unused_presc_we;
  assign unused_presc_we = write_en[PRESC_IDX];
  assign tick            = 1'b1;
  assign presc_w         = '0;
`endif

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    multi_timer_chan #(.WIDTH(WIDTH)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .we_count   (write_en[4*n]),
      .we_reload  (write_en[4*n+1]),
      .we_compare (write_en[4*n+2]),
      .we_config  (write_en[4*n+3]),
      .tick       (tick),
      .count      (ch_count[n]),
      .reload     (ch_reload[n]),
      .compare    (ch_compare[n]),
      .cfg        (ch_cfg[n]),
      .tp_set     (tp_set[n]),
      .cp_set     (cp_set[n])
    );
    assign ire[n] = ch_cfg[n][2];
  end

  always_comb begin
    tp_d = tp_q;
    cp_d = cp_q;
    if (write_en[STATUS_IDX]) begin
      tp_d = tp_d & ~data_in[CHANNELS-1:0];
      cp_d = cp_d & ~data_in[16 +: CHANNELS];
    end
    // Hardware sets are applied last so they win over a same-cycle clear.
    tp_d  = tp_d | tp_set;
    cp_d  = cp_d | cp_set;
    irq_d = |((tp_q | cp_q) & ire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tp_q  <= '0;
      cp_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      tp_q  <= tp_d;
      cp_q  <= cp_d;
      irq_q <= irq_d;
    end
  end

  always_comb begin
    status_w                  = '0;
    status_w[CHANNELS-1:0]    = tp_q;
    status_w[16 +: CHANNELS]  = cp_q;
    data_out                  = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      data_out[4*n]   = 32'(ch_count[n]);
      data_out[4*n+1] = 32'(ch_reload[n]);
      data_out[4*n+2] = 32'(ch_compare[n]);
      data_out[4*n+3] = 32'(ch_cfg[n]);
    end
    data_out[STATUS_IDX] = status_w;
    data_out[PRESC_IDX]  = presc_w;
  end

  assign irq_out = irq_q;
endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed test-plan steps plus random register
// traffic, every cycle compared against a rule-level model of the register map.
module tb_multi_timer;
  localparam int CH   = 4;
  localparam int REGS = 4*CH+2;

  logic                  clk, reset, irq_out;
  logic [31:0]           data_in;
  logic [REGS-1:0]       write_en;
  logic [REGS-1:0][31:0] data_out;
  int checks = 0, failures = 0;

  logic [31:0] m_cnt[CH], m_rel[CH], m_cmp[CH];
  logic [4:0]  m_cfg[CH];
  logic [CH-1:0] m_tp, m_cp;
  logic m_irq;
  int   m_p, m_ph;

  multi_timer dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .write_en (write_en),
    .data_out (data_out),
    .irq_out  (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_edge(input logic rst, input logic [REGS-1:0] we, input logic [31:0] d);
    logic [CH-1:0] st, sc;
    logic [31:0] c;
    logic up, tick, irq_next;
    if (rst) begin
      for (int n = 0; n < CH; n++) begin
        m_cnt[n] = 0; m_rel[n] = 0; m_cmp[n] = 0; m_cfg[n] = 0;
      end
      m_tp = 0; m_cp = 0; m_irq = 0; m_p = 0; m_ph = 0;
      return;
    end
`ifdef MULTI_TIMER_PRESCALE_EN
    tick = ((m_ph % (m_p + 1)) == m_p);
`else
    tick = 1'b1;
`endif
    irq_next = 1'b0;
    for (int n = 0; n < CH; n++) irq_next |= (m_tp[n] | m_cp[n]) & m_cfg[n][2];
    st = '0; sc = '0;
    for (int n = 0; n < CH; n++) begin
      c  = m_cnt[n];
      up = m_cfg[n][1];
      if (we[4*n]) m_cnt[n] = d;
      else if (m_cfg[n][0] && tick) begin
        if (c == m_cmp[n]) sc[n] = 1'b1;
        if (up ? (c == 32'hFFFF_FFFF) : (c == 0)) begin
          st[n]    = 1'b1;
          m_cnt[n] = m_cfg[n][3] ? m_rel[n] : (up ? 32'h0 : 32'hFFFF_FFFF);
          if (m_cfg[n][4]) m_cfg[n][0] = 1'b0;
        end else m_cnt[n] = up ? c + 1 : c - 1;
      end
      if (we[4*n+1]) m_rel[n] = d;
      if (we[4*n+2]) m_cmp[n] = d;
      if (we[4*n+3]) m_cfg[n] = d[4:0];
    end
    if (we[4*CH]) begin
      m_tp = m_tp & ~d[CH-1:0];
      m_cp = m_cp & ~d[16 +: CH];
    end
    m_tp = m_tp | st;
    m_cp = m_cp | sc;
`ifdef MULTI_TIMER_PRESCALE_EN
    if (we[4*CH+1]) begin m_p = int'(d[7:0]); m_ph = 0; end
    else m_ph++;
`endif
    m_irq = irq_next;
  endtask

  function automatic logic [31:0] exp_word(input int i);
    logic [31:0] w;
    w = 0;
    if (i < 4*CH) begin
      case (i % 4)
        0: w = m_cnt[i/4];
        1: w = m_rel[i/4];
        2: w = m_cmp[i/4];
        default: w = {27'b0, m_cfg[i/4]};
      endcase
    end else if (i == 4*CH) begin
      w[CH-1:0]   = m_tp;
      w[16 +: CH] = m_cp;
    end else begin
`ifdef MULTI_TIMER_PRESCALE_EN
      w = 32'(m_p);
`endif
    end
    return w;
  endfunction

  task automatic check_all();
    for (int i = 0; i < REGS; i++) begin
      checks++;
      assert (data_out[i] === exp_word(i)) else begin
        failures++;
        $error("FAIL word%0d got=%h exp=%h", i, data_out[i], exp_word(i));
      end
    end
    checks++;
    assert (irq_out === m_irq) else begin
      failures++;
      $error("FAIL irq got=%b exp=%b", irq_out, m_irq);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [REGS-1:0] we, input logic [31:0] d);
    write_en = we;
    data_in  = d;
    @(posedge clk);
    model_edge(reset, we, d);
    #1;
    write_en = '0;
    data_in  = '0;
    check_all();
  endtask

  task automatic wr(input int r, input logic [31:0] d);
    logic [REGS-1:0] w;
    w = '0;
    w[r] = 1'b1;
    cyc(w, d);
  endtask

  task automatic idle();
    cyc('0, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    int r, k;
    reset = 1'b1; write_en = '0; data_in = '0;
    idle(); idle();
    reset = 1'b0;
    for (int i = 0; i < REGS; i++) chk($sformatf("rst_w%0d", i), data_out[i], 32'h0);
    chk("rst_irq", 32'(irq_out), 32'h0);

    // Wrap at all-ones, up counting, interrupt masked
    wr(0, 32'hFFFF_FFFE);
    wr(3, 32'h3);
    chk("cnt0_fe", data_out[0], 32'hFFFF_FFFE);
    idle(); chk("cnt0_ff", data_out[0], 32'hFFFF_FFFF);
    idle(); chk("cnt0_wrap", data_out[0], 32'h0);
    chk("tp0_set", 32'(data_out[16][0]), 32'h1);
    chk("tp0_noirq", 32'(irq_out), 32'h0);
    wr(3, 32'h0);
    wr(16, 32'hFFFF_FFFF);

    // Auto-reload, down, one-shot
    wr(5, 32'd5); wr(4, 32'd1); wr(7, 32'h1D);
    chk("cnt1_1", data_out[4], 32'd1);
    idle(); chk("cnt1_0", data_out[4], 32'd0);
    idle(); chk("cnt1_reload", data_out[4], 32'd5);
    chk("tp1_set", 32'(data_out[16][1]), 32'h1);
    chk("cfg1_en_clr", data_out[7], 32'h1C);
    chk("irq_not_yet", 32'(irq_out), 32'h0);
    idle(); chk("irq_tp1", 32'(irq_out), 32'h1);
    chk("cnt1_hold", data_out[4], 32'd5);
    idle(); chk("cnt1_hold2", data_out[4], 32'd5);
    wr(16, 32'hFFFF_FFFF);
    idle(); chk("irq_tp1_clr", 32'(irq_out), 32'h0);
    wr(7, 32'h0);

    // Compare match and W1C
    wr(10, 32'd10); wr(8, 32'd8); wr(11, 32'h7);
    idle(); idle(); idle();
    chk("cnt2_11", data_out[8], 32'd11);
    chk("cp2_set", 32'(data_out[16][18]), 32'h1);
    idle(); chk("irq_cp2", 32'(irq_out), 32'h1);
    wr(16, 32'h40000);
    chk("cp2_clr", 32'(data_out[16][18]), 32'h0);
    idle(); chk("irq_cp2_clr", 32'(irq_out), 32'h0);
    wr(8, 32'd9); idle();
    wr(16, 32'h40000);
    chk("cp2_set_beats_clr", 32'(data_out[16][18]), 32'h1);
    wr(11, 32'h0); wr(16, 32'hFFFF_FFFF);

    // COUNT write beats a tick and suppresses events
    wr(2, 32'h77); wr(0, 32'h77); wr(3, 32'h3);
    chk("cnt0_77", data_out[0], 32'h77);
    wr(0, 32'd100);
    chk("cnt0_100", data_out[0], 32'd100);
    chk("cp0_none", 32'(data_out[16][16]), 32'h0);
    idle(); chk("cnt0_101", data_out[0], 32'd101);
    wr(3, 32'h0);

`ifdef MULTI_TIMER_PRESCALE_EN
    wr(0, 32'h0);
    wr(17, 32'h3);
    chk("presc_rd", data_out[17], 32'h3);
    wr(3, 32'h3);
    idle(); idle(); chk("pre_w3", data_out[0], 32'd0);
    idle(); chk("pre_w4", data_out[0], 32'd1);
    idle(); idle(); idle(); chk("pre_w7", data_out[0], 32'd1);
    idle(); chk("pre_w8", data_out[0], 32'd2);
    idle();
    wr(17, 32'h3);
    idle(); idle(); chk("pre_restart_w12", data_out[0], 32'd2);
    idle(); idle(); chk("pre_restart_w14", data_out[0], 32'd3);
    wr(17, 32'h0); wr(3, 32'h0);
`else
    wr(17, 32'h3);
    chk("presc_rd0", data_out[17], 32'h0);
    wr(0, 32'h0); wr(3, 32'h3);
    idle(); chk("nopre_1", data_out[0], 32'd1);
    idle(); chk("nopre_2", data_out[0], 32'd2);
    wr(3, 32'h0);
`endif

    // Random register traffic with occasional mid-run reset
    for (int t = 0; t < 600; t++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        reset = 1'b1;
        wr($urandom_range(0, REGS-1), $urandom);
        reset = 1'b0;
      end else if (r < 40) begin
        k = $urandom_range(0, REGS-1);
        if (k == 4*CH) d = $urandom;
        else if (k == 4*CH+1) d = ($urandom & 32'hFFFF_FF00) | $urandom_range(0, 3);
        else case (k % 4)
          0: case ($urandom_range(0, 4))
               0: d = $urandom;
               1: d = 32'hFFFF_FFFE;
               2: d = 32'hFFFF_FFFF;
               3: d = 32'h0;
               default: d = 32'h2;
             endcase
          1: d = $urandom_range(0, 8);
          2: d = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 6);
          default: d = $urandom;
        endcase
        wr(k, d);
      end else idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
